alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Registered execute stage that sits in front of the combinational `alu` and acts as its initiator. It accepts operations over a valid/ready handshake, drives the ALU's opcode and operand inputs, and captures `result`/`z`/`n`/`v`. It also maintains the architectural flag register and returns results through a 2-entry output buffer with its own valid/ready handshake. Downstream is register-file writeback; flag outputs feed branch resolution.

## Interface
- `DEPTH`, 2: output buffer entries (fixed at 2; parameter exists for the bench only)
- `clk`  in  1  clock; all state updates on posedge
- `rst_n`  in  1  reset; synchronous, active-low
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  stage can accept this cycle
- `in_opcode`  in  5  ALU opcode
- `in_a`, `in_b`  in  32  operands
- `in_rd`  in  4  destination tag, passed through
- `in_setf`  in  1  operation updates flag register
- `alu_opcode`  out  5  to ALU `opcode`
- `alu_a`, `alu_b`  out  32  to ALU `operand_a`/`operand_b`
- `alu_result`  in  32  from ALU `result`
- `alu_z`, `alu_n`, `alu_v`  in  1  from ALU flags
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  consumer takes head entry
- `out_result`  out  32  head result
- `out_rd`  out  4  head tag
- `out_err`  out  1  head entry had illegal opcode
- `flag_z`, `flag_n`, `flag_v`  out  1  architectural flags
- `err_cnt`  out  8  saturating illegal-opcode count

## Operation
- Legal opcodes: 0x02 sub, 0x03 add, 0x05 and, 0x06 or, 0x07 xor, 0x08 sll, 0x09 srl, 0x0A sra. Any other value is illegal.
- ALU drive is combinational pass-through: `alu_opcode=in_opcode`, `alu_a=in_a`, `alu_b=in_b` at all times.
- Accept occurs when `in_valid & in_ready`. On accept, push {`alu_result`, `in_rd`, err} into the buffer tail.
- Illegal opcode on accept:
  - store result 0 and err=1;
  - flags unchanged regardless of `in_setf`;
  - `err_cnt` increments and saturates at 0xFF.
- Legal opcode on accept with `in_setf=1`: flags load `alu_z`/`alu_n`/`alu_v` verbatim. Flags change in accept order, not drain order.
- Pop occurs when `out_valid & out_ready`. Order is strict FIFO.
- Buffer count is 0..2. `in_ready = (count != 2)`; it depends on registered state only.
- Push and pop in the same cycle: count unchanged, data ordering preserved. This cannot happen at count=2, because `in_ready` is low.
- `out_*` shows the head entry. When empty, `out_valid=0` and `out_result`/`out_rd`/`out_err` read 0.

## Timing
- Reset values: `out_valid=0`, `in_ready=1`, `out_result=0`, `out_rd=0`, `out_err=0`, all flags 0, `err_cnt=0`, count 0, pointers 0.
- Latency is 1 cycle: an accept at edge N gives `out_valid=1` after edge N when the buffer was empty.
- Flags are visible the cycle after accept.
- Throughput is 1 op/cycle while the consumer keeps `out_ready=1`.
- Full: with `out_ready=0`, two accepts are taken, `in_ready` drops, and the third offer stalls. `in_ready` returns the cycle after the first pop.
- Pointers are 1-bit and wrap 1→0.
- Reset mid-operation: buffer contents discarded, flags and `err_cnt` cleared. Any in-flight offer is not accepted on the reset edge.
- `in_*` are don't-care when `in_valid=0`; no state changes in that case.

## Structure
- Shared package `alu_pkg`:
  - opcode enum (`OP_SUB=5'h02` … `OP_SRA=5'h0A`);
  - `is_legal_op` function;
  - `alu_entry_t` struct {result, rd, err};
  - `DATA_W=32`, `TAG_W=4`.
- One sub-module `alu_out_fifo` (2-entry, count/pointer logic, push/pop) holds the buffer.
- The flag register, error counter and legality check stay in `alu_exec_stage`.
- `alu` is instantiated by the parent, not inside this block.

## Test plan
- Add 0xDEADBEEF+0x01234567, rd=3, setf=1, out_ready=1 → next cycle `out_result=0xDFD10456`, `out_rd=3`; flags match the ALU (z=0, n=1).
- Sequence back-to-back with `out_ready=1` → results in order at 1/cycle:
  - and → 0x00210467;
  - sll by 9 → 0x5B7DDE00;
  - srl by 4 → 0x0DEADBEE;
  - sra by 16 → 0xFFFFDEAD;
  - sub 0x0EADBEEF−0x01234567 → 0x0D8A7988.
- Backpressure, `out_ready=0`, three offers → two accepted, `in_ready=0`. Raise `out_ready` → entries drain in order and the third is accepted the cycle after the first pop. Include a simultaneous push+pop at count 1.
- Opcode 0x1F with setf=1 → `out_err=1`, `out_result=0`, flags unchanged, `err_cnt=1`. Then 300 illegal ops → `err_cnt=0xFF`.
- setf=0 on a zero-result xor (0x5A5A5A5A^0x5A5A5A5A) → `flag_z` stays 0. Repeat with setf=1 → `flag_z=1`.
- Assert `rst_n=0` for one edge with 2 entries buffered → `out_valid=0`, `in_ready=1`, flags 0, `err_cnt=0` after that edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: opcode encoding, legality check
// and the output-buffer entry layout.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  typedef enum logic [4:0] {
    OP_SUB = 5'h02,
    OP_ADD = 5'h03,
    OP_AND = 5'h05,
    OP_OR  = 5'h06,
    OP_XOR = 5'h07,
    OP_SLL = 5'h08,
    OP_SRL = 5'h09,
    OP_SRA = 5'h0A
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  rd;
    logic              err;
  } alu_entry_t;

  function automatic logic is_legal_op(input logic [4:0] op);
    case (op)
      OP_SUB, OP_ADD, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_out_fifo.sv
// Small result buffer between the execute stage and writeback.
// Strict FIFO; the head reads as all-zero whenever the buffer is empty.
module alu_out_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  alu_entry_t i_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output alu_entry_t o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  alu_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage is deliberately left without reset; validity is tracked by
  // r_count alone, so stale data is never observable and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage in front of the combinational ALU: accepts ops,
// captures results into a 2-entry buffer and owns the architectural flags.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_rd,
  input  logic              in_setf,
  output logic [4:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_rd,
  output logic              out_err,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  output logic [7:0]        err_cnt
);

  logic       w_accept;
  logic       w_pop;
  logic       w_legal;
  logic       w_full;
  logic       w_empty;
  alu_entry_t w_push_entry;
  alu_entry_t w_head;
  logic       r_flag_z;
  logic       r_flag_n;
  logic       r_flag_v;
  logic [7:0] r_err_cnt;

  assign alu_opcode = in_opcode;
  assign alu_a      = in_a;
  assign alu_b      = in_b;

  assign w_legal   = is_legal_op(in_opcode);
  assign in_ready  = ~w_full;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;

  // Illegal ops still occupy a slot so writeback sees them in program order.
  assign w_push_entry = '{result: (w_legal ? alu_result : '0), rd: in_rd, err: ~w_legal};

  alu_out_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign out_result = w_head.result;
  assign out_rd     = w_head.rd;
  assign out_err    = w_head.err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flag_z  <= 1'b0;
      r_flag_n  <= 1'b0;
      r_flag_v  <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_accept) begin
      if (!w_legal) begin
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end else if (in_setf) begin
        r_flag_z <= alu_z;
        r_flag_n <= alu_n;
        r_flag_v <= alu_v;
      end
    end
  end

  assign flag_z  = r_flag_z;
  assign flag_n  = r_flag_n;
  assign flag_v  = r_flag_v;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: behavioural ALU, queue-based
// reference model, directed vector table and randomized traffic.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_rd;
  logic        in_setf;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_z;
  logic        alu_n;
  logic        alu_v;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_err;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .in_setf    (in_setf),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .alu_v      (alu_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_err    (out_err),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_v     (flag_v),
    .err_cnt    (err_cnt)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        v;
  } alu_out_t;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        err;
  } ent_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic        setf;
    logic [31:0] exp_res;
  } vec_t;

  // Illegal opcodes produce garbage with all flags set, so any leak is visible.
  function automatic alu_out_t ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_out_t o;
    o = '0;
    case (op)
      5'h02: begin o.res = a - b; o.v = (a[31] != b[31]) && (o.res[31] != a[31]); end
      5'h03: begin o.res = a + b; o.v = (a[31] == b[31]) && (o.res[31] != a[31]); end
      5'h05: o.res = a & b;
      5'h06: o.res = a | b;
      5'h07: o.res = a ^ b;
      5'h08: o.res = a << b[4:0];
      5'h09: o.res = a >> b[4:0];
      5'h0A: o.res = $unsigned($signed(a) >>> b[4:0]);
      default: begin o.res = 32'hBAD0_BAD0; o.z = 1'b1; o.n = 1'b1; o.v = 1'b1; return o; end
    endcase
    o.z = (o.res == 32'd0);
    o.n = o.res[31];
    return o;
  endfunction

  function automatic logic ref_legal(input logic [4:0] op);
    return op inside {5'h02, 5'h03, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A};
  endfunction

  alu_out_t alu_o;
  always_comb begin
    alu_o      = ref_alu(alu_opcode, alu_a, alu_b);
    alu_result = alu_o.res;
    alu_z      = alu_o.z;
    alu_n      = alu_o.n;
    alu_v      = alu_o.v;
  end

  // Reference model state
  ent_t mq[$];
  logic m_z = 1'b0;
  logic m_n = 1'b0;
  logic m_v = 1'b0;
  int   m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    check({tag, ".out_valid"},  32'(out_valid),  32'(mq.size() != 0));
    check({tag, ".in_ready"},   32'(in_ready),   32'(mq.size() < 2));
    check({tag, ".out_result"}, out_result,      h.res);
    check({tag, ".out_rd"},     32'(out_rd),     32'(h.rd));
    check({tag, ".out_err"},    32'(out_err),    32'(h.err));
    check({tag, ".flags"},      32'({flag_z, flag_n, flag_v}), 32'({m_z, m_n, m_v}));
    check({tag, ".err_cnt"},    32'(err_cnt),    32'(m_err));
  endtask

  // One clock: apply inputs, advance the model across the edge, check after it.
  task automatic drive(input string tag, input logic v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] rd, input logic setf, input logic ordy);
    logic     acc;
    logic     pop;
    alu_out_t r;
    in_valid  = v;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_rd     = rd;
    in_setf   = setf;
    out_ready = ordy;
    acc = v && (mq.size() < 2);
    pop = ordy && (mq.size() != 0);
    r   = ref_alu(op, a, b);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_z = 1'b0; m_n = 1'b0; m_v = 1'b0; m_err = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        if (ref_legal(op)) begin
          mq.push_back('{res: r.res, rd: rd, err: 1'b0});
          if (setf) begin m_z = r.z; m_n = r.n; m_v = r.v; end
        end else begin
          mq.push_back('{res: 32'd0, rd: rd, err: 1'b1});
          if (m_err < 255) m_err++;
        end
      end
    end
    #1;
    check_state(tag);
  endtask

  task automatic idle(input string tag, input logic ordy);
    drive(tag, 1'b0, 5'h1F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 1'b1, ordy);
  endtask

  vec_t vecs[6];
  logic [4:0] legal_ops[8] = '{5'h02, 5'h03, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A};

  initial begin
    vecs[0] = '{op: 5'h03, a: 32'hDEADBEEF, b: 32'h01234567, rd: 4'd3, setf: 1'b1, exp_res: 32'hDFD10456};
    vecs[1] = '{op: 5'h05, a: 32'hDEADBEEF, b: 32'h01234567, rd: 4'd4, setf: 1'b0, exp_res: 32'h00210467};
    vecs[2] = '{op: 5'h08, a: 32'hDEADBEEF, b: 32'd9,        rd: 4'd5, setf: 1'b0, exp_res: 32'h5B7DDE00};
    vecs[3] = '{op: 5'h09, a: 32'hDEADBEEF, b: 32'd4,        rd: 4'd6, setf: 1'b0, exp_res: 32'h0DEADBEE};
    vecs[4] = '{op: 5'h0A, a: 32'hDEADBEEF, b: 32'd16,       rd: 4'd7, setf: 1'b0, exp_res: 32'hFFFFDEAD};
    vecs[5] = '{op: 5'h02, a: 32'h0EADBEEF, b: 32'h01234567, rd: 4'd8, setf: 1'b0, exp_res: 32'h0D8A7988};

    // Reset
    rst_n = 1'b0;
    idle("reset0", 1'b0);
    idle("reset1", 1'b0);
    rst_n = 1'b1;
    idle("post_reset", 1'b0);

    // Back-to-back directed vectors at full throughput
    for (int i = 0; i < 6; i++) begin
      drive("vec", 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].setf, 1'b1);
      check("vec.result", out_result, vecs[i].exp_res);
      check("vec.rd", 32'(out_rd), 32'(vecs[i].rd));
      if (i == 0) begin
        check("add.flag_z", 32'(flag_z), 32'd0);
        check("add.flag_n", 32'(flag_n), 32'd1);
      end
    end
    idle("drain", 1'b1);

    // Backpressure: two accepted, third stalls, then drains with push+pop at count 1
    drive("bp0", 1'b1, 5'h03, 32'd10, 32'd1, 4'd1, 1'b0, 1'b0);
    drive("bp1", 1'b1, 5'h03, 32'd20, 32'd2, 4'd2, 1'b0, 1'b0);
    check("bp.full_in_ready", 32'(in_ready), 32'd0);
    drive("bp2", 1'b1, 5'h03, 32'd30, 32'd3, 4'd3, 1'b0, 1'b0);
    check("bp.stall_head", out_result, 32'd11);
    drive("bp3", 1'b1, 5'h03, 32'd30, 32'd3, 4'd3, 1'b0, 1'b1);
    check("bp.after_pop_head", out_result, 32'd22);
    check("bp.ready_back", 32'(in_ready), 32'd1);
    drive("bp4", 1'b1, 5'h03, 32'd30, 32'd3, 4'd3, 1'b0, 1'b1);
    check("bp.third_head", out_result, 32'd33);
    idle("bp5", 1'b1);
    check("bp.empty", 32'(out_valid), 32'd0);

    // Illegal opcode: flags preserved, counter counts and saturates
    drive("set_n", 1'b1, 5'h03, 32'hDEADBEEF, 32'h01234567, 4'd1, 1'b1, 1'b1);
    drive("illegal", 1'b1, 5'h1F, 32'h1234, 32'h5678, 4'd9, 1'b1, 1'b1);
    check("illegal.err", 32'(out_err), 32'd1);
    check("illegal.result", out_result, 32'd0);
    check("illegal.err_cnt", 32'(err_cnt), 32'd1);
    check("illegal.flag_n", 32'(flag_n), 32'd1);
    for (int i = 0; i < 300; i++) begin
      logic [4:0] op;
      op = 5'(10 + $urandom_range(1, 21));
      drive("illegal_run", 1'b1, op, $urandom, $urandom, 4'($urandom), 1'b1, 1'b1);
    end
    check("illegal.saturated", 32'(err_cnt), 32'hFF);

    // Zero-result xor with and without flag update
    drive("xor_nosetf", 1'b1, 5'h07, 32'h5A5A5A5A, 32'h5A5A5A5A, 4'd2, 1'b0, 1'b1);
    check("xor_nosetf.flag_z", 32'(flag_z), 32'd0);
    drive("xor_setf", 1'b1, 5'h07, 32'h5A5A5A5A, 32'h5A5A5A5A, 4'd2, 1'b1, 1'b1);
    check("xor_setf.flag_z", 32'(flag_z), 32'd1);

    // Reset with two entries buffered and an offer pending
    drive("pre_rst0", 1'b1, 5'h06, 32'h0F0, 32'h00F, 4'd5, 1'b1, 1'b0);
    drive("pre_rst1", 1'b1, 5'h02, 32'd1, 32'd2, 4'd6, 1'b1, 1'b0);
    rst_n = 1'b0;
    drive("mid_rst", 1'b1, 5'h03, 32'd7, 32'd8, 4'd7, 1'b1, 1'b0);
    check("mid_rst.out_valid", 32'(out_valid), 32'd0);
    check("mid_rst.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    idle("after_rst", 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 7)];
      drive("rand", 1'($urandom_range(0, 3) != 0), op, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
            4'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) idle("final_drain", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
